// File: rtl/gauss_window_col_5.sv
// gauss_window_col_5: streaming 5-line window generator feeding the 5x5 Gaussian blur stage
// Accepts one raster-order pixel per valid clock and emits one registered vertical 5-pixel column.
// Ports:
//   PixelClk   pixel clock, all state on rising edge
//   nRST       asynchronous active-low reset
//   in_valid   input pixel valid (no backpressure)
//   in_pixel   input pixel
//   in_sof     start-of-frame marker, qualified by in_valid
//   out_valid  out_col/out_x/out_y valid (rows y>=4 only)
//   out_col    [PIX_W-1:0]=row y-4 ... [5*PIX_W-1:4*PIX_W]=row y
//   out_x      column index of out_col
//   out_y      centre row of the window (y-2)
//   out_eof    pulse with the column of the last pixel of the frame
// Optional: define SOF_RESYNC_EN to let in_valid&&in_sof force the pixel to x=0,y=0;
// without it in_sof is ignored.
module gauss_window_col_5 #(
  parameter int IMG_WIDTH  = 172,
  parameter int IMG_HEIGHT = 106,
  parameter int PIX_W      = 8
) (
  input  logic               PixelClk,
  input  logic               nRST,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic               in_sof,
  output logic               out_valid,
  output logic [5*PIX_W-1:0] out_col,
  output logic [9:0]         out_x,
  output logic [9:0]         out_y,
  output logic               out_eof
);
  localparam int AW = $clog2(IMG_WIDTH);
  localparam logic [9:0] X_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_HEIGHT - 1);
  logic [PIX_W-1:0]   lb_q [4][IMG_WIDTH];
  logic [9:0]         x_q, x_d, y_q, y_d, xe, ye;
  logic [AW-1:0]      a;
  logic [5*PIX_W-1:0] col_d, col_q;
  logic [9:0]         ox_q, oy_q;
  logic               valid_q, eof_q, sof;
`ifdef SOF_RESYNC_EN
  assign sof = in_valid && in_sof;
`else
  logic unused_sof;
  assign unused_sof = in_sof;
  assign sof = 1'b0;
`endif
  // xe/ye are the effective coordinates of the current pixel (resync overrides the counters)
  always_comb begin
    xe    = sof ? '0 : x_q;
    ye    = sof ? '0 : y_q;
    x_d   = (xe == X_LAST) ? '0 : xe + 10'd1;
    y_d   = (xe != X_LAST) ? ye : (ye == Y_LAST) ? '0 : ye + 10'd1;
    col_d = {in_pixel, lb_q[0][a], lb_q[1][a], lb_q[2][a], lb_q[3][a]};
  end
  assign a = xe[AW-1:0];
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      col_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      valid_q <= in_valid && (ye >= 10'd4);
      eof_q   <= in_valid && (xe == X_LAST) && (ye == Y_LAST);
      if (in_valid) begin
        x_q   <= x_d;
        y_q   <= y_d;
        col_q <= col_d;
        ox_q  <= xe;
        oy_q  <= ye - 10'd2;
      end
    end
  end
  // Buffers shift down one row per column; reads above use the pre-write contents.
  always_ff @(posedge PixelClk) begin
    if (in_valid) begin
      lb_q[0][a] <= in_pixel;
      lb_q[1][a] <= lb_q[0][a];
      lb_q[2][a] <= lb_q[1][a];
      lb_q[3][a] <= lb_q[2][a];
    end
  end
  assign out_valid = valid_q;
  assign out_col   = col_q;
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign out_eof   = eof_q;
endmodule

// File: tb/tb_gauss_window_col_5.sv
// tb_gauss_window_col_5: directed self-checking bench for gauss_window_col_5
module tb_gauss_window_col_5;
  logic        clk = 1'b0, nrst = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic [7:0]  in_pixel = '0;
  logic        out_valid, out_eof;
  logic [39:0] out_col;
  logic [9:0]  out_x, out_y;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  gauss_window_col_5 dut (
    .PixelClk(clk), .nRST(nrst), .in_valid(in_valid), .in_pixel(in_pixel), .in_sof(in_sof),
    .out_valid(out_valid), .out_col(out_col), .out_x(out_x), .out_y(out_y), .out_eof(out_eof)
  );
  task automatic drive(input logic v, input logic [7:0] p, input logic s);
    in_valid = v; in_pixel = p; in_sof = s;
    @(posedge clk); #1;
  endtask
  task automatic do_reset;
    in_valid = 0; in_sof = 0; nrst = 0;
    repeat (2) @(posedge clk);
    #1 nrst = 1;
  endtask
  task automatic test_reset;
    in_valid = 0; nrst = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_col !== 40'h0) begin bad++; $display("FAIL reset_col got=%h want=0", out_col); end
    total++; if (out_x !== 10'd0) begin bad++; $display("FAIL reset_x got=%0d want=0", out_x); end
    total++; if (out_y !== 10'd0) begin bad++; $display("FAIL reset_y got=%0d want=0", out_y); end
    total++; if (out_eof !== 1'b0) begin bad++; $display("FAIL reset_eof got=%b want=0", out_eof); end
    nrst = 1;
  endtask
  task automatic test_raster;
    int nv, ne, first, ex, ey;
    logic ev;
    logic [39:0] e, fcol;
    do_reset;
    nv = 0; ne = 0; first = -1; ex = -1; ey = -1; fcol = '0;
    for (int y = 0; y < 106; y++) for (int x = 0; x < 172; x++) begin
      drive(1, 8'(y), 0);
      ev = (y >= 4);
      total++; if (out_valid !== ev) begin bad++; if (bad < 30) $display("FAIL raster_valid x=%0d y=%0d got=%b want=%b", x, y, out_valid, ev); end
      total++; if (out_eof !== (x == 171 && y == 105)) begin bad++; if (bad < 30) $display("FAIL raster_eof x=%0d y=%0d got=%b", x, y, out_eof); end
      if (ev) begin
        e = {8'(y), 8'(y - 1), 8'(y - 2), 8'(y - 3), 8'(y - 4)};
        total++;
        if (out_col !== e || out_x !== 10'(x) || out_y !== 10'(y - 2)) begin
          bad++; if (bad < 30) $display("FAIL raster_col got=%h/%0d/%0d want=%h/%0d/%0d", out_col, out_x, out_y, e, x, y - 2);
        end
      end
      if (out_valid === 1'b1) begin
        if (first < 0) begin first = y * 172 + x; fcol = out_col; end
        nv++;
      end
      if (out_eof === 1'b1) begin ne++; ex = int'(out_x); ey = int'(out_y); end
    end
    in_valid = 0;
    total++; if (first != 688) begin bad++; $display("FAIL raster_first got=%0d want=688", first); end
    total++; if (fcol !== 40'h0403020100) begin bad++; $display("FAIL raster_first_col got=%h want=0403020100", fcol); end
    total++; if (nv != 17544) begin bad++; $display("FAIL raster_count got=%0d want=17544", nv); end
    total++; if (ne != 1) begin bad++; $display("FAIL raster_eof_count got=%0d want=1", ne); end
    total++; if (ex != 171 || ey != 103) begin bad++; $display("FAIL raster_eof_pos got=%0d,%0d want=171,103", ex, ey); end
  endtask
  task automatic test_gaps;
    logic ev;
    do_reset;
    for (int y = 0; y < 6; y++) for (int x = 0; x < 172; x++) begin
      drive(1, 8'(x), 0);
      ev = (y >= 4);
      total++; if (out_valid !== ev) begin bad++; if (bad < 30) $display("FAIL gaps_valid x=%0d y=%0d got=%b want=%b", x, y, out_valid, ev); end
      if (ev) begin
        total++;
        if (out_col !== {5{8'(x)}} || out_x !== 10'(x) || out_y !== 10'(y - 2)) begin
          bad++; if (bad < 30) $display("FAIL gaps_col got=%h/%0d/%0d want=%h/%0d/%0d", out_col, out_x, out_y, {5{8'(x)}}, x, y - 2);
        end
      end
      drive(0, 8'hEE, 0);
      total++; if (out_valid !== 1'b0 || out_eof !== 1'b0) begin bad++; if (bad < 30) $display("FAIL gaps_idle x=%0d y=%0d got=%b%b want=00", x, y, out_valid, out_eof); end
    end
  endtask
  task automatic test_back_to_back;
    logic ev;
    do_reset;
    for (int y = 0; y < 106; y++) for (int x = 0; x < 172; x++) begin
      drive(1, 8'hAA, 0);
      ev = (y >= 4);
      total++; if (out_valid !== ev) begin bad++; if (bad < 30) $display("FAIL b2b_a_valid x=%0d y=%0d got=%b want=%b", x, y, out_valid, ev); end
      if (ev) begin
        total++; if (out_col !== 40'hAAAAAAAAAA) begin bad++; if (bad < 30) $display("FAIL b2b_a_col got=%h want=aaaaaaaaaa", out_col); end
      end
    end
    for (int i = 0; i < 4 * 172; i++) begin
      drive(1, 8'h55, 0);
      total++; if (out_valid !== 1'b0 || out_eof !== 1'b0) begin bad++; if (bad < 30) $display("FAIL b2b_b_prime i=%0d got=%b%b want=00", i, out_valid, out_eof); end
    end
    drive(1, 8'h55, 0);
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_b_valid got=%b want=1", out_valid); end
    total++; if (out_col !== 40'h5555555555) begin bad++; $display("FAIL b2b_b_col got=%h want=5555555555", out_col); end
    total++; if (out_x !== 10'd0 || out_y !== 10'd2) begin bad++; $display("FAIL b2b_b_pos got=%0d,%0d want=0,2", out_x, out_y); end
  endtask
  task automatic test_reset_mid;
    do_reset;
    for (int i = 0; i < 50 * 172 + 80; i++) drive(1, 8'(i / 172), 0);
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", out_valid); end
    nrst = 0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b want=0", out_valid); end
    total++; if (out_x !== 10'd0 || out_y !== 10'd0 || out_col !== 40'h0) begin bad++; $display("FAIL mid_async_out got=%0d,%0d,%h want=0,0,0", out_x, out_y, out_col); end
    repeat (3) @(posedge clk);
    #1 nrst = 1;
    for (int i = 0; i <= 688; i++) begin
      drive(1, 8'(i / 172 + 16), 0);
      if (i < 688) begin
        total++; if (out_valid !== 1'b0) begin bad++; if (bad < 30) $display("FAIL mid_prime i=%0d got=%b want=0", i, out_valid); end
      end else begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_first_valid got=%b want=1", out_valid); end
        total++; if (out_x !== 10'd0 || out_y !== 10'd2) begin bad++; $display("FAIL mid_first_pos got=%0d,%0d want=0,2", out_x, out_y); end
        total++; if (out_col !== 40'h1413121110) begin bad++; $display("FAIL mid_first_col got=%h want=1413121110", out_col); end
      end
    end
    in_valid = 0;
  endtask
  task automatic test_sof;
    do_reset;
    for (int i = 0; i < 30 * 172 + 17; i++) drive(1, 8'h11, 0);
    drive(1, 8'h33, 1);
    in_sof = 0;
`ifdef SOF_RESYNC_EN
    total++; if (out_valid !== 1'b0 || out_eof !== 1'b0) begin bad++; $display("FAIL sof_pixel got=%b%b want=00", out_valid, out_eof); end
    for (int i = 1; i <= 688; i++) begin
      drive(1, 8'h22, 0);
      if (i < 688) begin
        total++; if (out_valid !== 1'b0 || out_eof !== 1'b0) begin bad++; if (bad < 30) $display("FAIL sof_prime i=%0d got=%b%b want=00", i, out_valid, out_eof); end
      end else begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sof_first_valid got=%b want=1", out_valid); end
        total++; if (out_x !== 10'd0 || out_y !== 10'd2) begin bad++; $display("FAIL sof_first_pos got=%0d,%0d want=0,2", out_x, out_y); end
        total++; if (out_col !== 40'h2222222233) begin bad++; $display("FAIL sof_first_col got=%h want=2222222233", out_col); end
      end
    end
`else
    total++; if (out_valid !== 1'b1 || out_eof !== 1'b0) begin bad++; $display("FAIL nosof_flags got=%b%b want=10", out_valid, out_eof); end
    total++; if (out_x !== 10'd17 || out_y !== 10'd28) begin bad++; $display("FAIL nosof_pos got=%0d,%0d want=17,28", out_x, out_y); end
    total++; if (out_col !== 40'h3311111111) begin bad++; $display("FAIL nosof_col got=%h want=3311111111", out_col); end
`endif
    in_valid = 0;
  endtask
  initial begin
    test_reset;
    test_raster;
    test_gaps;
    test_back_to_back;
    test_reset_mid;
    test_sof;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
